// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART RX byte stream (SYNC CMD LEN payload CHK) into checked command packets
// with a host-readable payload buffer. Define UART_FRAME_STATS_EN to add good/error frame counters.
module uart_rx_frame_ctrl #(
    parameter int         CLKS_PER_BIT = 87,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Enable,
    input  logic                       i_RX_DV,
    input  logic [7:0]                 i_RX_Byte,
    input  logic [$clog2(MAX_LEN)-1:0] i_Rd_Addr,
    output logic [7:0]                 o_Rd_Data,
    output logic                       o_Frame_Valid,
    output logic [7:0]                 o_Cmd,
    output logic [7:0]                 o_Frame_Len,
    output logic                       o_Err,
    output logic [1:0]                 o_Err_Code,
`ifdef UART_FRAME_STATS_EN
    output logic [15:0]                o_Good_Count,
    output logic [15:0]                o_Err_Count,
`endif
    output logic                       o_Busy
);

    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam int AW           = $clog2(MAX_LEN);

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

    typedef enum logic [2:0] {IDLE, GET_CMD, GET_LEN, GET_DATA, GET_CHK} state_t;

    state_t          state;
    logic [7:0]      cmd_sh;
    logic [7:0]      len_sh;
    logic [7:0]      sum;
    logic [AW-1:0]   idx;
    logic [TW-1:0]   to_cnt;
    logic [7:0]      mem [MAX_LEN];

    logic            wr_en;
    logic            timeout_hit;

    assign wr_en       = (state == GET_DATA) && i_RX_DV && i_Enable;
    // Fires on the clock where the idle count would reach TIMEOUT_CLKS.
    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CLKS - 1));
    assign o_Busy      = (state != IDLE);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= IDLE;
            cmd_sh        <= '0;
            len_sh        <= '0;
            sum           <= '0;
            idx           <= '0;
            to_cnt        <= '0;
            o_Frame_Valid <= 1'b0;
            o_Err         <= 1'b0;
            o_Err_Code    <= '0;
            o_Cmd         <= '0;
            o_Frame_Len   <= '0;
        end else begin
            o_Frame_Valid <= 1'b0;
            o_Err         <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                idx    <= '0;
                if (i_RX_DV && i_Enable && (i_RX_Byte == SYNC_BYTE))
                    state <= GET_CMD;
            end else if (!i_Enable) begin
                // Silent abort: no error, no commit.
                state  <= IDLE;
                to_cnt <= '0;
            end else if (i_RX_DV) begin
                to_cnt <= '0;
                case (state)
                    GET_CMD: begin
                        cmd_sh <= i_RX_Byte;
                        sum    <= i_RX_Byte;
                        state  <= GET_LEN;
                    end
                    GET_LEN: begin
                        len_sh <= i_RX_Byte;
                        sum    <= sum + i_RX_Byte;
                        idx    <= '0;
                        if (i_RX_Byte > 8'(MAX_LEN)) begin
                            o_Err      <= 1'b1;
                            o_Err_Code <= ERR_LEN;
                            state      <= IDLE;
                        end else if (i_RX_Byte == 8'd0) begin
                            state <= GET_CHK;
                        end else begin
                            state <= GET_DATA;
                        end
                    end
                    GET_DATA: begin
                        sum <= sum + i_RX_Byte;
                        if (8'(idx) == len_sh - 8'd1) begin
                            idx   <= '0;
                            state <= GET_CHK;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                    GET_CHK: begin
                        if (i_RX_Byte == sum) begin
                            o_Frame_Valid <= 1'b1;
                            o_Cmd         <= cmd_sh;
                            o_Frame_Len   <= len_sh;
                        end else begin
                            o_Err      <= 1'b1;
                            o_Err_Code <= ERR_CHK;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout_hit) begin
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_TO;
                state      <= IDLE;
                to_cnt     <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Payload RAM is deliberately left unreset.
    always_ff @(posedge i_Clock) begin
        if (wr_en)
            mem[idx] <= i_RX_Byte;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)
            o_Rd_Data <= '0;
        else
            o_Rd_Data <= mem[i_Rd_Addr];
    end

`ifdef UART_FRAME_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Good_Count <= '0;
            o_Err_Count  <= '0;
        end else begin
            if (o_Frame_Valid)
                o_Good_Count <= sat_inc16(o_Good_Count);
            if (o_Err)
                o_Err_Count <= sat_inc16(o_Err_Count);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed byte frames, expected frame/error events queued and checked by a monitor.
module tb_uart_rx_frame_ctrl;

    localparam int TIMEOUT_CLKS = 20 * 87;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [7:0] cmd;
    logic [7:0] frame_len;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_cyc = 0;

    logic [7:0] good_cmd = 8'h00;
    logic [7:0] good_len = 8'h00;

    typedef struct {
        bit         is_err;
        logic [7:0] cmd;
        logic [7:0] len;
        logic [1:0] code;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];

    uart_rx_frame_ctrl dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Enable      (rx_enable),
        .i_RX_DV       (rx_dv),
        .i_RX_Byte     (rx_byte),
        .i_Rd_Addr     (rd_addr),
        .o_Rd_Data     (rd_data),
        .o_Frame_Valid (frame_valid),
        .o_Cmd         (cmd),
        .o_Frame_Len   (frame_len),
        .o_Err         (err),
        .o_Err_Code    (err_code),
        .o_Busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every frame/error pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (frame_valid || err)) begin
            chk("valid_err_exclusive", {31'd0, frame_valid & err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, frame_valid, err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind_err", {31'd0, err}, {31'd0, e.is_err});
                chk("event_cycle", cyc, e.cyc);
                if (e.is_err)
                    chk("err_code", {30'd0, err_code}, {30'd0, e.code});
                chk("cmd", {24'd0, cmd}, {24'd0, e.cmd});
                chk("frame_len", {24'd0, frame_len}, {24'd0, e.len});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dv    = 1'b1;
        rx_byte  = b;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_good(input logic [7:0] c, input logic [7:0] l);
        ev_t e;
        good_cmd = c;
        good_len = l;
        e = '{is_err: 1'b0, cmd: c, len: l, code: 2'b00, cyc: last_cyc + 1};
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] code, input int at_cyc);
        ev_t e;
        e = '{is_err: 1'b1, cmd: good_cmd, len: good_len, code: code, cyc: at_cyc};
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] s;
        rst       = 1'b1;
        rx_enable = 1'b1;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        rd_addr   = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy",     {31'd0, busy}, 32'd0);
        chk("reset_valid",    {31'd0, frame_valid}, 32'd0);
        chk("reset_err",      {31'd0, err}, 32'd0);
        chk("reset_err_code", {30'd0, err_code}, 32'd0);
        chk("reset_cmd",      {24'd0, cmd}, 32'd0);
        chk("reset_len",      {24'd0, frame_len}, 32'd0);
        chk("reset_rd_data",  {24'd0, rd_data}, 32'd0);
        rst = 1'b0;

        // Basic two-byte payload frame.
        send(8'hA5); send(8'h10);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        send(8'h02); send(8'h01); send(8'h02); send(8'h15);
        expect_good(8'h10, 8'h02);
        idle(3);
        rd(4'd0, 8'h01, "t1_rd0");
        rd(4'd1, 8'h02, "t1_rd1");
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // Noise before SYNC, zero-length frame (checksum = CMD + LEN = 22).
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h22); send(8'h00); send(8'h22);
        expect_good(8'h22, 8'h00);
        idle(3);

        // Bad checksum: error 10, held CMD/LEN stay 22/00.
        send(8'hA5); send(8'h10); send(8'h02); send(8'h01); send(8'h02); send(8'h16);
        expect_err(2'b10, last_cyc + 1);
        idle(3);

        // LEN 0x11 > MAX_LEN, then a back-to-back MAX_LEN frame.
        send(8'hA5); send(8'h10); send(8'h11);
        expect_err(2'b01, last_cyc + 1);
        send(8'hA5); send(8'h40); send(8'h10);
        s = 8'h50;
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            s = s + 8'(i);
        end
        chk("t4_sum_const", {24'd0, s}, 32'h0000_00C8);
        send(s);
        expect_good(8'h40, 8'h10);
        idle(3);
        rd(4'd0,  8'h00, "t4_rd0");
        rd(4'd7,  8'h07, "t4_rd7");
        rd(4'd15, 8'h0F, "t4_rd15");
        chk("t4_err_code_held", {30'd0, err_code}, 32'd1);

        // Enable low: SYNC ignored; enable dropped mid-frame aborts silently.
        rx_enable = 1'b0;
        send(8'hA5); send(8'h33);
        idle(2);
        chk("en_low_busy", {31'd0, busy}, 32'd0);
        rx_enable = 1'b1;
        send(8'hA5); send(8'h20);
        @(negedge clk);
        rx_dv     = 1'b0;
        rx_enable = 1'b0;
        @(negedge clk);
        rx_enable = 1'b1;
        chk("en_drop_busy", {31'd0, busy}, 32'd0);
        idle(3);
        chk("en_drop_busy_later", {31'd0, busy}, 32'd0);

        // Inter-byte timeout after CMD.
        send(8'hA5); send(8'h10);
        t = last_cyc + 1 + TIMEOUT_CLKS;
        expect_err(2'b11, t);
        idle(0);
        while (cyc < t - 1) @(negedge clk);
        chk("busy_before_timeout", {31'd0, busy}, 32'd1);
        while (cyc < t + 1) @(negedge clk);
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);

        // DV on the expiry clock wins over the timeout.
        send(8'hA5); send(8'h10);
        t = last_cyc + 1 + TIMEOUT_CLKS;
        idle(0);
        while (cyc < t - 2) @(negedge clk);
        send(8'h00);
        chk("dv_at_expiry_cycle", last_cyc + 1, t);
        send(8'h10);
        expect_good(8'h10, 8'h00);
        idle(3);
        chk("t5_err_code_held", {30'd0, err_code}, 32'd3);

        // Async reset mid-payload, then a full frame.
        send(8'hA5); send(8'h30); send(8'h03); send(8'hAA); send(8'hBB);
        @(posedge clk);
        #2;
        rx_dv = 1'b0;
        rst   = 1'b1;
        #1;
        chk("rst_mid_busy",  {31'd0, busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_mid_err",   {31'd0, err}, 32'd0);
        chk("rst_mid_cmd",   {24'd0, cmd}, 32'd0);
        good_cmd = 8'h00;
        good_len = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8'hA5); send(8'h30); send(8'h01); send(8'h7F); send(8'hB0);
        expect_good(8'h30, 8'h01);
        idle(3);
        rd(4'd0, 8'h7F, "t6_rd0");

        idle(5);
        chk("pending_events", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
